// File: rtl/coherence_pkg.sv
// rtl/coherence_pkg.sv - shared types for the cache coherence channel
package coherence_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SNOOP  = 2'd1,
    MEM_WR = 2'd2
  } coh_state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } coh_side_t;

  // Address 15:0 = tag 15:8, index 7:1, offset 0
  typedef struct packed {
    logic [7:0] tag;
    logic [6:0] index;
    logic       offset;
  } coh_addr_t;

  // Message 31:0 = data 31:16, address 15:0
  typedef struct packed {
    logic [15:0] data;
    coh_addr_t   addr;
  } coh_msg_t;

  // A snoop is always delivered to the cache that did not originate the write
  function automatic coh_side_t opposite(input coh_side_t s);
    return (s == LEFT) ? RIGHT : LEFT;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin arbiter with one-bit pointer
module rr_arbiter_2
  import coherence_pkg::*;
(
  input  logic [1:0] req_i,       // bit 0 = left, bit 1 = right
  input  coh_side_t  ptr_i,
  input  logic       advance_i,
  output logic [1:0] winner_o,    // one-hot, same bit order as req_i
  output coh_side_t  ptr_next_o
);

  // Pick the pointed side on a collision, otherwise whoever asks; after a grant
  // the pointer favours the side that did not win
  always_comb begin
    winner_o   = req_i;
    ptr_next_o = ptr_i;
    if (req_i == 2'b11) begin
      winner_o = (ptr_i == LEFT) ? 2'b01 : 2'b10;
    end
    if (advance_i && (winner_o != 2'b00)) begin
      ptr_next_o = winner_o[0] ? RIGHT : LEFT;
    end
  end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// rtl/coherence_bus_arbiter.sv - serialises cache write-change messages into snoop then memory write
module coherence_bus_arbiter
  import coherence_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 16,
  parameter int SNOOP_TIMEOUT = 15
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             left_req,
  input  logic [DATA_WIDTH+ADDR_WIDTH-1:0] left_msg,
  input  logic                             right_req,
  input  logic [DATA_WIDTH+ADDR_WIDTH-1:0] right_msg,
  output logic                             left_grant,
  output logic                             right_grant,
  output logic                             left_snoop_valid,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] left_snoop_msg,
  input  logic                             left_snoop_ack,
  output logic                             right_snoop_valid,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] right_snoop_msg,
  input  logic                             right_snoop_ack,
  output logic                             mem_wr_valid,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] mem_wr_msg,
  input  logic                             mem_wr_ready,
  output logic                             busy,
  output logic                             snoop_timeout_err
);

  localparam int MW = DATA_WIDTH + ADDR_WIDTH;
  // Last SNOOP cycle index before giving up; the counter reads SNOOP_TIMEOUT after it
  localparam logic [3:0] TO_LAST = 4'(SNOOP_TIMEOUT - 1);

  coh_state_t      state_q, state_d;
  coh_side_t       src_q, src_d;
  coh_side_t       ptr_q, ptr_next;
  logic [MW-1:0]   msg_q, msg_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            lgrant_q, lgrant_d;
  logic            rgrant_q, rgrant_d;
  logic            lsv_q, lsv_d;
  logic            rsv_q, rsv_d;
  logic [MW-1:0]   lsm_q, lsm_d;
  logic [MW-1:0]   rsm_q, rsm_d;
  logic            mwv_q, mwv_d;
  logic [MW-1:0]   mwm_q, mwm_d;
  logic            busy_q, busy_d;

  logic [1:0]      winner;
  logic            advance;
  logic            snoop_ack;
  coh_side_t       tgt_d;

  rr_arbiter_2 u_rr (
    .req_i      ({right_req, left_req}),
    .ptr_i      (ptr_q),
    .advance_i  (advance),
    .winner_o   (winner),
    .ptr_next_o (ptr_next)
  );

  // Acks only count from the cache currently being shown a snoop
  assign snoop_ack = (lsv_q & left_snoop_ack) | (rsv_q & right_snoop_ack);

  // Next-state, message latch, timeout counter and next values of every output flop
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    msg_d    = msg_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    lgrant_d = 1'b0;
    rgrant_d = 1'b0;
    advance  = 1'b0;

    case (state_q)
      IDLE: begin
        if (left_req || right_req) begin
          advance = 1'b1;
          state_d = SNOOP;
          cnt_d   = 4'd0;
          if (winner[0]) begin
            src_d    = LEFT;
            msg_d    = left_msg;
            lgrant_d = 1'b1;
          end else begin
            src_d    = RIGHT;
            msg_d    = right_msg;
            rgrant_d = 1'b1;
          end
        end
      end
      SNOOP: begin
        // An ack on the final allowed cycle still wins over the timeout
        if (snoop_ack) begin
          state_d = MEM_WR;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = cnt_q + 4'd1;
          err_d   = 1'b1;
          state_d = MEM_WR;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      MEM_WR: begin
        if (mwv_q && mem_wr_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    tgt_d  = opposite(src_d);
    lsv_d  = (state_d == SNOOP) && (tgt_d == LEFT);
    rsv_d  = (state_d == SNOOP) && (tgt_d == RIGHT);
    lsm_d  = lsv_d ? msg_d : '0;
    rsm_d  = rsv_d ? msg_d : '0;
    mwv_d  = (state_d == MEM_WR);
    mwm_d  = mwv_d ? msg_d : '0;
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset discards any in-flight transaction
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      src_q    <= LEFT;
      ptr_q    <= LEFT;
      msg_q    <= '0;
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
      lgrant_q <= 1'b0;
      rgrant_q <= 1'b0;
      lsv_q    <= 1'b0;
      rsv_q    <= 1'b0;
      lsm_q    <= '0;
      rsm_q    <= '0;
      mwv_q    <= 1'b0;
      mwm_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      ptr_q    <= ptr_next;
      msg_q    <= msg_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      lgrant_q <= lgrant_d;
      rgrant_q <= rgrant_d;
      lsv_q    <= lsv_d;
      rsv_q    <= rsv_d;
      lsm_q    <= lsm_d;
      rsm_q    <= rsm_d;
      mwv_q    <= mwv_d;
      mwm_q    <= mwm_d;
      busy_q   <= busy_d;
    end
  end

  assign left_grant        = lgrant_q;
  assign right_grant       = rgrant_q;
  assign left_snoop_valid  = lsv_q;
  assign right_snoop_valid = rsv_q;
  assign left_snoop_msg    = lsm_q;
  assign right_snoop_msg   = rsm_q;
  assign mem_wr_valid      = mwv_q;
  assign mem_wr_msg        = mwm_q;
  assign busy              = busy_q;
  assign snoop_timeout_err = err_q;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// tb/tb_coherence_bus_arbiter.sv - self-checking bench for coherence_bus_arbiter
module tb_coherence_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        left_req, right_req;
  logic [31:0] left_msg, right_msg;
  logic        left_grant, right_grant;
  logic        left_snoop_valid, right_snoop_valid;
  logic [31:0] left_snoop_msg, right_snoop_msg;
  logic        left_snoop_ack, right_snoop_ack;
  logic        mem_wr_valid;
  logic [31:0] mem_wr_msg;
  logic        mem_wr_ready;
  logic        busy;
  logic        snoop_timeout_err;

  int tests  = 0;
  int failed = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        lreq;
    logic        rreq;
    logic [31:0] lmsg;
    logic [31:0] rmsg;
    logic        exp_left;
  } vec_t;

  vec_t vecs[7];

  always #5 clock = ~clock;

  coherence_bus_arbiter #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .SNOOP_TIMEOUT(15)
  ) dut (
    .clock(clock), .reset(reset),
    .left_req(left_req), .left_msg(left_msg),
    .right_req(right_req), .right_msg(right_msg),
    .left_grant(left_grant), .right_grant(right_grant),
    .left_snoop_valid(left_snoop_valid), .left_snoop_msg(left_snoop_msg),
    .left_snoop_ack(left_snoop_ack),
    .right_snoop_valid(right_snoop_valid), .right_snoop_msg(right_snoop_msg),
    .right_snoop_ack(right_snoop_ack),
    .mem_wr_valid(mem_wr_valid), .mem_wr_msg(mem_wr_msg), .mem_wr_ready(mem_wr_ready),
    .busy(busy), .snoop_timeout_err(snoop_timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bits"}, {25'd0, left_grant, right_grant, left_snoop_valid, right_snoop_valid,
                           mem_wr_valid, busy, snoop_timeout_err}, 32'd0);
    check({tag, "_lsm"}, left_snoop_msg, 32'd0);
    check({tag, "_rsm"}, right_snoop_msg, 32'd0);
    check({tag, "_mwm"}, mem_wr_msg, 32'd0);
  endtask

  // Scoreboard: every accepted memory write must match the oldest expected message
  always @(negedge clock) begin
    if (reset === 1'b1 && mem_wr_valid === 1'b1 && mem_wr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL sb_unexpected_write: actual=%h required=none", mem_wr_msg);
      end else begin
        check("sb_mem_write", mem_wr_msg, exp_q.pop_front());
      end
    end
  end

  // One full transaction from IDLE with ack and ready held high
  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] win;
    win = v.exp_left ? v.lmsg : v.rmsg;
    left_req  = v.lreq;
    right_req = v.rreq;
    left_msg  = v.lmsg;
    right_msg = v.rmsg;
    exp_q.push_back(win);
    step();
    check({tag, "_lgrant"}, left_grant, v.exp_left);
    check({tag, "_rgrant"}, right_grant, !v.exp_left);
    check({tag, "_busy1"}, busy, 1'b1);
    check({tag, "_lsv"}, left_snoop_valid, !v.exp_left);
    check({tag, "_rsv"}, right_snoop_valid, v.exp_left);
    check({tag, "_tgt_msg"}, v.exp_left ? right_snoop_msg : left_snoop_msg, win);
    check({tag, "_src_msg"}, v.exp_left ? left_snoop_msg : right_snoop_msg, 32'd0);
    left_req  = 1'b0;
    right_req = 1'b0;
    step();
    check({tag, "_mwv"}, mem_wr_valid, 1'b1);
    check({tag, "_mwm"}, mem_wr_msg, win);
    check({tag, "_c2_grants"}, {left_grant, right_grant, left_snoop_valid, right_snoop_valid}, 4'b0000);
    step();
    check({tag, "_c3_idle"}, {busy, mem_wr_valid}, 2'b00);
  endtask

  initial begin
    vecs[0] = '{lreq: 1'b1, rreq: 1'b0, lmsg: 32'hBEEF_0042, rmsg: 32'h0,           exp_left: 1'b1};
    vecs[1] = '{lreq: 1'b1, rreq: 1'b1, lmsg: 32'h1111_0001, rmsg: 32'h2222_0002, exp_left: 1'b0};
    vecs[2] = '{lreq: 1'b1, rreq: 1'b1, lmsg: 32'h3333_0003, rmsg: 32'h4444_0004, exp_left: 1'b1};
    vecs[3] = '{lreq: 1'b1, rreq: 1'b0, lmsg: 32'h5555_0005, rmsg: 32'h6666_0006, exp_left: 1'b1};
    vecs[4] = '{lreq: 1'b1, rreq: 1'b1, lmsg: 32'h7777_0007, rmsg: 32'h8888_0008, exp_left: 1'b0};
    vecs[5] = '{lreq: 1'b0, rreq: 1'b1, lmsg: 32'h9999_0009, rmsg: 32'hAAAA_000A, exp_left: 1'b0};
    vecs[6] = '{lreq: 1'b1, rreq: 1'b1, lmsg: 32'hBBBB_000B, rmsg: 32'hCCCC_000C, exp_left: 1'b1};

    reset = 1'b0;
    left_req = 1'b0; right_req = 1'b0;
    left_msg = '0;   right_msg = '0;
    left_snoop_ack = 1'b1; right_snoop_ack = 1'b1;
    mem_wr_ready = 1'b1;
    step(2);
    check_all_zero("reset");
    reset = 1'b1;
    step();
    check_all_zero("post_reset");

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Collision from reset: left, then pending right, then left again
    reset = 1'b0;
    step();
    reset = 1'b1;
    left_req = 1'b1; right_req = 1'b1;
    left_msg = 32'hC001_0001; right_msg = 32'hC002_0002;
    exp_q.push_back(32'hC001_0001);
    exp_q.push_back(32'hC002_0002);
    step();
    check("col_c1_lgrant", {left_grant, right_grant}, 2'b10);
    left_req = 1'b0;
    step(3);
    check("col_c4_rgrant", {left_grant, right_grant}, 2'b01);
    check("col_c4_lsm", left_snoop_msg, 32'hC002_0002);
    left_req = 1'b1; left_msg = 32'hC003_0003;
    right_msg = 32'hC004_0004;
    exp_q.push_back(32'hC003_0003);
    exp_q.push_back(32'hC004_0004);
    step(3);
    check("col_c7_lgrant", {left_grant, right_grant}, 2'b10);
    left_req = 1'b0;
    step(3);
    check("col_c10_rgrant", {left_grant, right_grant}, 2'b01);
    right_req = 1'b0;
    step(3);

    // Ack on the final allowed snoop cycle counts as success
    right_snoop_ack = 1'b0;
    left_req = 1'b1; left_msg = 32'hA11A_0015;
    exp_q.push_back(32'hA11A_0015);
    step();
    left_req = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      check($sformatf("lim_c%0d_rsv", k), right_snoop_valid, 1'b1);
      step();
    end
    check("lim_c15_rsv", right_snoop_valid, 1'b1);
    right_snoop_ack = 1'b1;
    step();
    check("lim_c16_err", snoop_timeout_err, 1'b0);
    check("lim_c16_mwv", {mem_wr_valid, right_snoop_valid}, 2'b10);
    step();

    // Snoop never acked: 15 SNOOP cycles, then error plus write-through
    right_snoop_ack = 1'b0;
    left_req = 1'b1; left_msg = 32'hDEAD_00F0;
    exp_q.push_back(32'hDEAD_00F0);
    step();
    left_req = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      check($sformatf("to_c%0d", k), {right_snoop_valid, snoop_timeout_err, mem_wr_valid}, 3'b100);
      step();
    end
    check("to_c16_err", snoop_timeout_err, 1'b1);
    check("to_c16_rsv", right_snoop_valid, 1'b0);
    check("to_c16_mwv", mem_wr_valid, 1'b1);
    check("to_c16_mwm", mem_wr_msg, 32'hDEAD_00F0);
    step();
    check("to_c17_sticky", {snoop_timeout_err, busy}, 2'b10);
    right_snoop_ack = 1'b1;
    step();

    // Memory backpressure, then reset mid-write; the write must not replay
    mem_wr_ready = 1'b0;
    left_req = 1'b1; left_msg = 32'hBAD0_0777;
    step();
    left_req = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_%0d_mwv", k), mem_wr_valid, 1'b1);
      check($sformatf("bp_%0d_mwm", k), mem_wr_msg, 32'hBAD0_0777);
      step();
    end
    right_req = 1'b1; right_msg = 32'h600D_0888;
    reset = 1'b0;
    step();
    check_all_zero("midrst");
    reset = 1'b1;
    mem_wr_ready = 1'b1;
    exp_q.push_back(32'h600D_0888);
    step();
    check("rst_rgrant", {left_grant, right_grant}, 2'b01);
    check("rst_lsv", left_snoop_valid, 1'b1);
    check("rst_lsm", left_snoop_msg, 32'h600D_0888);
    right_req = 1'b0;
    step(4);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
